uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Standalone UART receiver. Deserialises an 8-bit asynchronous serial frame from rx_pin: 1 start bit, 8 data bits LSB first, optional even parity bit, 1 stop bit.
- Receive-side counterpart to the UART transmit path, with a matching frame format.
- Sits between the pad/loopback wire and the core that consumes rx_data. Reports parity and framing errors alongside each received byte.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115_200: line rate in bits/s.
- OVERSAMPLE, 16: sample ticks per bit. Must be even and >= 4.
- TICK_DIV, CLK_FREQ/(BAUD*OVERSAMPLE) (integer truncation): clocks per sample tick. Elaboration fails if < 1.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset. Asserted when 0; all state clears immediately.
- rx_pin, input, 1: serial line, idle high, asynchronous to clk.
- parity_enable, input, 1: 1 = frame carries an even parity bit after D7. Sampled at start-bit validation and held for the whole frame.
- rx_data, output, 8: last received byte.
- data_ready, output, 1: single-clk pulse; rx_data and both error flags are valid in this cycle.
- parity_err, output, 1: parity mismatch on the last frame. Forced 0 when parity was disabled.
- frame_err, output, 1: stop bit sampled low on the last frame.

Behaviour:
- Reset (reset=0), asynchronous:
  - rx_data=0x00, data_ready=0, parity_err=0, frame_err=0.
  - State=IDLE; tick and bit counters=0; synchronizer flops=1.
- Input conditioning:
  - 2-flop synchronizer on rx_pin; all logic uses the synchronized value rxs.
  - Latency of 2 clk is allowed.
- Tick generator:
  - Counter 0..TICK_DIV-1 emits a 1-clk tick at wrap.
  - Free-running, but cleared on the IDLE->START transition so sampling phase aligns to the start edge.
- FSM states and transitions:
  - IDLE: rxs=0 -> START, tick count=0.
  - START: at tick OVERSAMPLE/2 (mid-bit), re-sample rxs.
    - rxs=1: false start (glitch); return to IDLE with no outputs.
    - rxs=0: latch parity_enable, go to DATA, bit index=0.
  - DATA: sample every OVERSAMPLE ticks into a shift register, LSB first. After bit 7: go to PARITY if enabled, else STOP.
  - PARITY: sample one bit. Expected value = XOR of the 8 data bits (even parity); store the mismatch.
  - STOP: sample one bit.
    - Load rx_data, drive parity_err and frame_err (frame_err = ~sample), pulse data_ready for exactly one clk.
    - Stop sampled 1: go to IDLE.
    - Stop sampled 0: go to BREAK.
  - BREAK: wait until rxs=1, then go to IDLE. Prevents a held-low line from producing repeated frames.
- Output holding: rx_data, parity_err and frame_err hold their values until the next data_ready. data_ready is never high for 2 consecutive clks.
- Back-to-back frames: returning to IDLE at mid-stop-bit lets a start bit that immediately follows be detected without loss.
- Async reset mid-frame: return to IDLE at once. No data_ready for the partial frame; outputs return to reset values.
- parity_enable changing mid-frame has no effect until the next start bit.
- Timing with TICK_DIV=1, OVERSAMPLE=16 (bit period 16 clk), measured from the rx_pin falling edge:
  - START sample ~ +10 clk (2-clk synchronizer + 8 ticks).
  - data_ready ~ +10 + 16*(9+parity_enable) clk.
  - Timing tolerance is +/-2 clk.

Test Plan:
- Bench setup: CLK_FREQ=1_600_000, BAUD=100_000 (TICK_DIV=1, 16 clk/bit); reset held low for 3 clk, then released.
- parity_enable=1, send 0xA5 with parity 0 and stop 1 -> one data_ready pulse, rx_data=0xA5, parity_err=0, frame_err=0.
- parity_enable=1, send 0x3C with wrong parity 1 -> data_ready, rx_data=0x3C, parity_err=1, frame_err=0. Next good frame 0x01 (parity 1) clears parity_err to 0.
- parity_enable=0, send 0xFF with stop bit 0 and hold the line low 40 clk -> exactly one data_ready, rx_data=0xFF, frame_err=1. No further pulses until the line goes high; a following frame 0x55 is received cleanly.
- 4-clk low glitch on an idle line -> no data_ready, FSM back in IDLE; a following frame 0x80 is received correctly.
- Drive reset low at mid-DATA (bit 3) of a 0x12 frame, release, then send 0x34 -> no pulse for 0x12, outputs 0 during reset, then data_ready with rx_data=0x34.
- Loopback against the UART transmitter, parity_enable=1, 3 back-to-back bytes 0x00, 0x7E, 0xFF -> 3 data_ready pulses in order, all error flags 0.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver.
// Frame: 1 start bit, 8 data bits LSB first, optional even parity bit, 1 stop bit.
// Each received byte is reported with parity and framing error flags.
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int TICK_DIV   = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_pin,
  input  logic       parity_enable,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       parity_err,
  output logic       frame_err
);

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("uart_rx: TICK_DIV must be >= 1");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx: OVERSAMPLE must be even and >= 4");
  end

  localparam int TD_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [TD_W-1:0] TD_LAST = TD_W'(TICK_DIV - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t          state, state_nxt;
  logic            sync1, rxs;
  logic [TD_W-1:0] tick_cnt;
  logic            tick;
  logic [OS_W-1:0] os_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            par_en_q;
  logic            par_mis;
  logic            start_edge;
  logic            sample;
  logic            busy;

  // Two-flop synchronizer; idles high to match the line's idle level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_pin;
      rxs   <= sync1;
    end
  end

  assign tick = (tick_cnt == TD_LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!rxs) state_nxt = S_START;
      S_START:  if (sample) state_nxt = rxs ? S_IDLE : S_DATA;
      S_DATA:   if (sample && bit_idx == 3'd7) state_nxt = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (sample) state_nxt = S_STOP;
      // Leaving at mid-stop-bit leaves half a bit to catch a following start edge
      S_STOP:   if (sample) state_nxt = rxs ? S_IDLE : S_BREAK;
      S_BREAK:  if (rxs) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM control strobes: start detection and per-state sample point
  always_comb begin
    start_edge = 1'b0;
    sample     = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE:  start_edge = !rxs;
      S_START: begin
        busy   = 1'b1;
        sample = tick && (os_cnt == OS_MID);
      end
      S_DATA, S_PARITY, S_STOP: begin
        busy   = 1'b1;
        sample = tick && (os_cnt == OS_LAST);
      end
      default: ;
    endcase
  end

  // Tick and oversample counters; both realign to the detected start edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      os_cnt   <= '0;
    end else begin
      if (start_edge || tick) tick_cnt <= '0;
      else                    tick_cnt <= tick_cnt + 1'b1;
      if (start_edge)         os_cnt <= '0;
      else if (tick && busy)  os_cnt <= sample ? '0 : os_cnt + 1'b1;
    end
  end

  // Receive datapath and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_idx    <= '0;
      shift      <= '0;
      par_en_q   <= 1'b0;
      par_mis    <= 1'b0;
      rx_data    <= '0;
      data_ready <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      if (sample) begin
        case (state)
          S_START: if (!rxs) begin
            par_en_q <= parity_enable;
            par_mis  <= 1'b0;
            bit_idx  <= '0;
          end
          S_DATA: begin
            shift   <= {rxs, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end
          S_PARITY: par_mis <= rxs ^ (^shift);
          S_STOP: begin
            rx_data    <= shift;
            parity_err <= par_en_q & par_mis;
            frame_err  <= ~rxs;
            data_ready <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed tests for uart_rx at 16 clk per bit.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_pin = 1'b1;
  logic       parity_enable = 1'b0;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;

  int passed = 0;
  int total  = 0;

  // Pulse log filled by the monitor
  int         rdy_cnt = 0;
  logic [7:0] cap_data[$];
  logic       cap_pe[$];
  logic       cap_fe[$];
  logic       prev_rdy = 1'b0;
  logic       dbl_pulse = 1'b0;

  uart_rx #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (100_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_pin       (rx_pin),
    .parity_enable(parity_enable),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .parity_err   (parity_err),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // Record every data_ready pulse away from the active edge
  always @(negedge clk) begin
    if (data_ready === 1'b1) begin
      rdy_cnt++;
      cap_data.push_back(rx_data);
      cap_pe.push_back(parity_err);
      cap_fe.push_back(frame_err);
      if (prev_rdy === 1'b1) dbl_pulse = 1'b1;
    end
    prev_rdy = data_ready;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx_pin = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic with_par,
                            input logic par_bit, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (with_par) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got=%h exp=00", rx_data); else passed++;
    total++; if (data_ready !== 1'b0) $display("FAIL reset_data_ready got=%b exp=0", data_ready); else passed++;
    total++; if (parity_err !== 1'b0) $display("FAIL reset_parity_err got=%b exp=0", parity_err); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got=%b exp=0", frame_err); else passed++;
    reset = 1'b1;
    idle(5);
  endtask

  task automatic test_parity_good;
    int n0 = rdy_cnt;
    parity_enable = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    idle(20);
    total++; if (rdy_cnt !== n0 + 1) $display("FAIL good_pulse_count got=%0d exp=%0d", rdy_cnt, n0 + 1); else passed++;
    if (rdy_cnt > n0) begin
      total++; if (cap_data[n0] !== 8'hA5) $display("FAIL good_data got=%h exp=a5", cap_data[n0]); else passed++;
      total++; if (cap_pe[n0] !== 1'b0) $display("FAIL good_parity_err got=%b exp=0", cap_pe[n0]); else passed++;
      total++; if (cap_fe[n0] !== 1'b0) $display("FAIL good_frame_err got=%b exp=0", cap_fe[n0]); else passed++;
    end
  endtask

  task automatic test_parity_bad;
    int n0 = rdy_cnt;
    parity_enable = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    idle(20);
    total++; if (rdy_cnt !== n0 + 1) $display("FAIL bad_pulse_count got=%0d exp=%0d", rdy_cnt, n0 + 1); else passed++;
    total++; if (rx_data !== 8'h3C) $display("FAIL bad_data got=%h exp=3c", rx_data); else passed++;
    total++; if (parity_err !== 1'b1) $display("FAIL bad_parity_err got=%b exp=1", parity_err); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL bad_frame_err got=%b exp=0", frame_err); else passed++;
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    idle(20);
    total++; if (rdy_cnt !== n0 + 2) $display("FAIL clear_pulse_count got=%0d exp=%0d", rdy_cnt, n0 + 2); else passed++;
    total++; if (rx_data !== 8'h01) $display("FAIL clear_data got=%h exp=01", rx_data); else passed++;
    total++; if (parity_err !== 1'b0) $display("FAIL clear_parity_err got=%b exp=0", parity_err); else passed++;
  endtask

  task automatic test_break;
    int n0 = rdy_cnt;
    parity_enable = 1'b0;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    idle(40);
    total++; if (rdy_cnt !== n0 + 1) $display("FAIL break_pulse_count got=%0d exp=%0d", rdy_cnt, n0 + 1); else passed++;
    total++; if (rx_data !== 8'hFF) $display("FAIL break_data got=%h exp=ff", rx_data); else passed++;
    total++; if (frame_err !== 1'b1) $display("FAIL break_frame_err got=%b exp=1", frame_err); else passed++;
    total++; if (parity_err !== 1'b0) $display("FAIL break_parity_err got=%b exp=0", parity_err); else passed++;
    rx_pin = 1'b1;
    idle(20);
    total++; if (rdy_cnt !== n0 + 1) $display("FAIL break_release_count got=%0d exp=%0d", rdy_cnt, n0 + 1); else passed++;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    idle(20);
    total++; if (rdy_cnt !== n0 + 2) $display("FAIL after_break_count got=%0d exp=%0d", rdy_cnt, n0 + 2); else passed++;
    total++; if (rx_data !== 8'h55) $display("FAIL after_break_data got=%h exp=55", rx_data); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL after_break_frame_err got=%b exp=0", frame_err); else passed++;
  endtask

  task automatic test_glitch;
    int n0 = rdy_cnt;
    rx_pin = 1'b0;
    idle(4);
    rx_pin = 1'b1;
    idle(40);
    total++; if (rdy_cnt !== n0) $display("FAIL glitch_pulse_count got=%0d exp=%0d", rdy_cnt, n0); else passed++;
    parity_enable = 1'b1;
    send_frame(8'h80, 1'b1, 1'b1, 1'b1);
    idle(20);
    total++; if (rdy_cnt !== n0 + 1) $display("FAIL after_glitch_count got=%0d exp=%0d", rdy_cnt, n0 + 1); else passed++;
    total++; if (rx_data !== 8'h80) $display("FAIL after_glitch_data got=%h exp=80", rx_data); else passed++;
    total++; if (parity_err !== 1'b0) $display("FAIL after_glitch_parity_err got=%b exp=0", parity_err); else passed++;
  endtask

  task automatic test_reset_mid_frame;
    int n0 = rdy_cnt;
    logic [7:0] d = 8'h12;
    parity_enable = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx_pin = d[3];
    idle(8);
    reset = 1'b0;
    @(negedge clk);
    total++; if (rx_data !== 8'h00) $display("FAIL midreset_rx_data got=%h exp=00", rx_data); else passed++;
    total++; if (parity_err !== 1'b0 || frame_err !== 1'b0) $display("FAIL midreset_flags got=%b%b exp=00", parity_err, frame_err); else passed++;
    idle(2);
    rx_pin = 1'b1;
    reset = 1'b1;
    idle(200);
    total++; if (rdy_cnt !== n0) $display("FAIL midreset_pulse_count got=%0d exp=%0d", rdy_cnt, n0); else passed++;
    send_frame(8'h34, 1'b0, 1'b0, 1'b1);
    idle(20);
    total++; if (rdy_cnt !== n0 + 1) $display("FAIL post_reset_count got=%0d exp=%0d", rdy_cnt, n0 + 1); else passed++;
    total++; if (rx_data !== 8'h34) $display("FAIL post_reset_data got=%h exp=34", rx_data); else passed++;
  endtask

  task automatic test_back_to_back;
    int n0 = rdy_cnt;
    logic [7:0] exp_d [3] = '{8'h00, 8'h7E, 8'hFF};
    parity_enable = 1'b1;
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
    idle(20);
    total++; if (rdy_cnt !== n0 + 3) $display("FAIL b2b_pulse_count got=%0d exp=%0d", rdy_cnt, n0 + 3); else passed++;
    for (int i = 0; i < 3; i++) begin
      if (n0 + i < rdy_cnt) begin
        total++; if (cap_data[n0 + i] !== exp_d[i]) $display("FAIL b2b_data%0d got=%h exp=%h", i, cap_data[n0 + i], exp_d[i]); else passed++;
        total++; if (cap_pe[n0 + i] !== 1'b0 || cap_fe[n0 + i] !== 1'b0) $display("FAIL b2b_flags%0d got=%b%b exp=00", i, cap_pe[n0 + i], cap_fe[n0 + i]); else passed++;
      end
    end
    total++; if (dbl_pulse !== 1'b0) $display("FAIL single_cycle_pulse got=%b exp=0", dbl_pulse); else passed++;
  endtask

  initial begin
    test_reset;
    test_parity_good;
    test_parity_bad;
    test_break;
    test_glitch;
    test_reset_mid_frame;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
